pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the enable and clear controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard sources in fixed priority:
  - data-memory wait (handshake with a timeout),
  - taken-branch redirect,
  - load-use hazard.
- Keeps a saturating stall-cycle counter and raises a sticky error flag on memory timeout.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and widths for the pipeline stall/flush sequencer.
// Imported by the top-level controller and by the load-use comparator.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0     = 5'd0;
    localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID operand that depends on a load still in EX.
// Writes to x0 never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use  = ex_is_load && (ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > branch > load-use.
// Controls are combinational from state and inputs; a memory timeout parks the block in ERR.
//
// state    | meaning
// RUN      | normal flow; branch and load-use hazards resolved here
// MEM_WAIT | data memory outstanding; pipeline frozen, WB bubbled
// ERR      | memory timed out; everything frozen until reset
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_flush;
    logic w_ex_mem_en;
    logic w_mem_wb_flush;

    hazard_detect u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .load_use   (w_load_use)
    );

    assign w_mem_stall = ((r_state == RUN) && mem_req && !mem_ready) ||
                         ((r_state == MEM_WAIT) && !mem_ready);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_nxt      = r_err;
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b1;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_en    = 1'b1;
        w_mem_wb_flush = 1'b0;

        if (r_state == ERR) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (w_mem_stall) begin
            // WB is bubbled so the frozen MEM instruction does not retire twice.
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_flush = 1'b1;
            if (r_state == RUN) begin
                w_state_nxt    = MEM_WAIT;
                w_wait_cnt_nxt = WAIT_CNT_W'(1);
            end else if (r_wait_cnt == TIMEOUT_V) begin
                w_state_nxt = ERR;
                w_err_nxt   = 1'b1;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
            end
        end else begin
            if (r_state == MEM_WAIT) begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
            // A taken branch makes ID wrong-path, so its load-use hazard is moot.
            if (ex_br_taken) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
            end
        end

        if (reset) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_if_id_flush  = 1'b0;
            w_id_ex_en     = 1'b0;
            w_id_ex_flush  = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err      <= w_err_nxt;
            if (!w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en        = w_pc_en;
    assign if_id_en     = w_if_id_en;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_en     = w_id_ex_en;
    assign id_ex_flush  = w_id_ex_flush;
    assign ex_mem_en    = w_ex_mem_en;
    assign mem_wb_flush = w_mem_wb_flush;
    assign err          = r_err;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short timeout and a 2-bit stall counter.
// Each step queues its expected controls/err/stall_cnt and checks them mid-cycle.
module tb_pipeline_ctrl;

    localparam int TO = 4;
    localparam int CW = 2;

    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_FRZ  = 7'b0000001;
    localparam logic [6:0] C_RST  = 7'b0000000;

    typedef struct packed {
        logic [6:0]    ctl;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, mem_req, mem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic          err;
    logic [CW-1:0] stall_cnt;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_flush (mem_wb_flush),
        .err          (err),
        .stall_cnt    (stall_cnt)
    );

    wire [6:0] w_ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

    task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                         input logic br, input logic req, input logic rdy);
        reset       = rst;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd       = rd;
        ex_is_load  = ld;
        ex_br_taken = br;
        mem_req     = req;
        mem_ready   = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic lu_rs1();
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic step(input string tag, input logic [6:0] c, input logic e, input logic [CW-1:0] n);
        exp_t  x;
        string t;
        exp_q.push_back('{ctl: c, err: e, cnt: n});
        tag_q.push_back(tag);
        #2;
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (w_ctl === x.ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%b expected=%b", t, w_ctl, x.ctl);
        end
        checks++;
        assert (err === x.err) else begin
            failures++;
            $error("FAIL %s err observed=%b expected=%b", t, err, x.err);
        end
        checks++;
        assert (stall_cnt === x.cnt) else begin
            failures++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", t, stall_cnt, x.cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset with hazards asserted: controls must still be forced low.
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        step("reset_force", C_RST, 1'b0, 2'd0);
        idle();              step("idle",          C_NORM, 1'b0, 2'd0);

        lu_rs1();            step("lu_rs1",        C_LU,   1'b0, 2'd0);
        idle();              step("lu_cnt",        C_NORM, 1'b0, 2'd1);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
                             step("lu_x0",         C_NORM, 1'b0, 2'd1);
        drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
                             step("lu_nouse",      C_NORM, 1'b0, 2'd1);
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
                             step("lu_noload",     C_NORM, 1'b0, 2'd1);
        drive(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
                             step("lu_rs2",        C_LU,   1'b0, 2'd1);
        drive(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
                             step("br_over_lu",    C_BR,   1'b0, 2'd2);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
                             step("mem_ready_now", C_NORM, 1'b0, 2'd2);

        idle(); reset = 1'b1; step("rst1",         C_RST,  1'b0, 2'd2);
        idle();              step("rst1_clr",      C_NORM, 1'b0, 2'd0);

        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                             step("mw_0",          C_FRZ,  1'b0, 2'd0);
                             step("mw_1",          C_FRZ,  1'b0, 2'd1);
                             step("mw_2",          C_FRZ,  1'b0, 2'd2);
        mem_ready = 1'b1;    step("mw_release",    C_NORM, 1'b0, 2'd3);
        idle();              step("mw_after",      C_NORM, 1'b0, 2'd3);

        idle(); reset = 1'b1; step("rst2",         C_RST,  1'b0, 2'd3);
        idle();              step("rst2_clr",      C_NORM, 1'b0, 2'd0);

        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
                             step("bw_0",          C_FRZ,  1'b0, 2'd0);
                             step("bw_1",          C_FRZ,  1'b0, 2'd1);
        mem_ready = 1'b1;    step("bw_release",    C_BR,   1'b0, 2'd2);
        idle();              step("bw_after",      C_NORM, 1'b0, 2'd2);

        idle(); reset = 1'b1; step("rst3",         C_RST,  1'b0, 2'd2);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                             step("to_run",        C_FRZ,  1'b0, 2'd0);
                             step("to_w1",         C_FRZ,  1'b0, 2'd1);
                             step("to_w2",         C_FRZ,  1'b0, 2'd2);
                             step("to_w3",         C_FRZ,  1'b0, 2'd3);
                             step("to_w4",         C_FRZ,  1'b0, 2'd3);
                             step("to_err",        C_FRZ,  1'b1, 2'd3);
        mem_ready = 1'b1;    step("err_ready",     C_FRZ,  1'b1, 2'd3);
        idle();              step("err_idle",      C_FRZ,  1'b1, 2'd3);
        idle(); reset = 1'b1; step("rst_err",      C_RST,  1'b1, 2'd3);
        idle();              step("rst_err_clr",   C_NORM, 1'b0, 2'd0);

        lu_rs1();            step("sat_0",         C_LU,   1'b0, 2'd0);
                             step("sat_1",         C_LU,   1'b0, 2'd1);
                             step("sat_2",         C_LU,   1'b0, 2'd2);
                             step("sat_3",         C_LU,   1'b0, 2'd3);
                             step("sat_4",         C_LU,   1'b0, 2'd3);
                             step("sat_5",         C_LU,   1'b0, 2'd3);
        idle();              step("sat_hold",      C_NORM, 1'b0, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
